// File: rtl/mode2_sub_pipe.sv
// Softmax mode-2 subtract stage: out lane = sat(a lane - row max), two-stage valid/ready pipeline.
// Optional sticky per-lane saturation flags are built only when MODE2_SUB_SAT_FLAGS_EN is defined.
module mode2_sub_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANES  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            b_load,
  input  logic [DATA_WIDTH-1:0]           b_in,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] a_data,
  input  logic                            a_last,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0] out_data,
  output logic                            out_last,
  output logic [NUM_LANES-1:0]            sat_flags,
  input  logic                            sat_clr
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0]             b_reg;
  logic                     s1_valid, s1_last;
  logic [NUM_LANES*W-1:0]   s1_data;
  logic [W-1:0]             s1_b;
  logic                     s2_valid, s2_last;
  logic [NUM_LANES*W-1:0]   s2_data;
  logic [NUM_LANES*W-1:0]   res;
  logic [NUM_LANES-1:0]     lane_sat;
  logic [W:0]               diff;
  logic                     s2_adv;
  logic                     accept;

  assign s2_adv  = !s2_valid || out_ready;
  assign a_ready = !s1_valid || s2_adv;
  assign accept  = a_valid && a_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      b_reg <= '0;
    else if (b_load) b_reg <= b_in;
  end

  // S1 snapshots b_reg so later b_load writes never reach beats already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_data  <= '0;
      s1_b     <= '0;
    end else if (a_ready) begin
      s1_valid <= a_valid;
      if (accept) begin
        s1_data <= a_data;
        s1_last <= a_last;
        s1_b    <= b_reg;
      end
    end
  end

  // Overflow of the W+1-bit difference shows as disagreeing top two bits.
  always_comb begin
    res      = '0;
    lane_sat = '0;
    diff     = '0;
    for (int unsigned i = 0; i < NUM_LANES; i++) begin
      diff = {s1_data[i*W+W-1], s1_data[i*W +: W]} - {s1_b[W-1], s1_b};
      if (diff[W] != diff[W-1]) begin
        lane_sat[i]    = 1'b1;
        res[i*W +: W]  = diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      end else begin
        res[i*W +: W]  = diff[W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_last  <= 1'b0;
      s2_data  <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= res;
        s2_last <= s1_last;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_last  = s2_last;

`ifdef MODE2_SUB_SAT_FLAGS_EN
  logic [NUM_LANES-1:0] flags;

  // Set wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags <= '0;
    else        flags <= (sat_clr ? '0 : flags) | ((s2_adv && s1_valid) ? lane_sat : '0);
  end

  assign sat_flags = flags;
`else
  logic unused_sat;
  assign unused_sat = ^{sat_clr, lane_sat};
  assign sat_flags  = '0;
`endif

endmodule
